// File: rtl/bq_coef_loader.sv
// bq_coef_loader: Wishbone classic master that writes one biquad coefficient
// set (a11,a12,b10,b11,b12) and optionally reads it back for verification.
module bq_coef_loader #(
  parameter int          COEFWIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255,
  parameter int          VERIFY    = 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  input  logic [5*COEFWIDTH-1:0] coef_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic [2:0]             err_idx_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [31:0]            wb_adr_o,
  output logic [31:0]            wb_dat_o,
  output logic [3:0]             wb_sel_o,
  input  logic [31:0]            wb_dat_i,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i
);

  localparam int CW = COEFWIDTH;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WREQ, WGAP, RREQ, RGAP, FIN
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [5*CW-1:0]  coef_q, coef_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [2:0]       eidx_q, eidx_d;

  logic [CW-1:0]    cur_coef;
  logic [CW+15:0]   wr_wide;
  logic [15:0]      wr16;
  logic [15:0]      rd_sh;
  logic             rd_match;
  logic             req;

  always_comb begin
    cur_coef = coef_q[CW-1:0];
    case (idx_q)
      3'd1:    cur_coef = coef_q[2*CW-1:CW];
      3'd2:    cur_coef = coef_q[3*CW-1:2*CW];
      3'd3:    cur_coef = coef_q[4*CW-1:3*CW];
      3'd4:    cur_coef = coef_q[5*CW-1:4*CW];
      default: cur_coef = coef_q[CW-1:0];
    endcase
  end

  // Left-justify into a 16-bit word; only the top CW bits are meaningful.
  assign wr_wide  = {cur_coef, 16'h0000};
  assign wr16     = wr_wide[CW+15:CW];
  assign rd_sh    = wb_dat_i[15:0] >> (16 - CW);
  assign rd_match = (rd_sh[CW-1:0] == cur_coef);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      coef_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      coef_q  <= coef_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    coef_d  = coef_q;
    err_d   = err_q;
    code_d  = code_q;
    eidx_d  = eidx_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          coef_d  = coef_i;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          code_d  = '0;
          eidx_d  = '0;
          state_d = WREQ;
        end
      end
      WREQ, RREQ: begin
        // err has priority over a simultaneous ack
        if (wb_err_i) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          eidx_d  = idx_q;
          state_d = FIN;
        end else if (wb_ack_i) begin
          if (state_q == RREQ && !rd_match) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            eidx_d  = idx_q;
            state_d = FIN;
          end else begin
            state_d = (state_q == WREQ) ? WGAP : RGAP;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          eidx_d  = idx_q;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WGAP: begin
        cnt_d = '0;
        if (idx_q < 3'd4) begin
          idx_d   = idx_q + 3'd1;
          state_d = WREQ;
        end else if (VERIFY != 0) begin
          idx_d   = '0;
          state_d = RREQ;
        end else begin
          state_d = FIN;
        end
      end
      RGAP: begin
        cnt_d = '0;
        if (idx_q < 3'd4) begin
          idx_d   = idx_q + 3'd1;
          state_d = RREQ;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode the state register so reset clears them at once.
  assign req        = (state_q == WREQ) || (state_q == RREQ);
  assign wb_cyc_o   = req;
  assign wb_stb_o   = req;
  assign wb_we_o    = (state_q == WREQ);
  assign wb_sel_o   = {4{req}};
  assign wb_adr_o   = req ? (BASE_ADDR + {27'd0, idx_q, 2'b00}) : 32'h0;
  assign wb_dat_o   = (state_q == WREQ) ? {{16{wr16[15]}}, wr16} : 32'h0;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == FIN);
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign err_idx_o  = eidx_q;

endmodule
